mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit in the EX stage, beside the ALU. Takes the same
//  rs/rt operands and executes MULT/MULTU/DIV/DIVU into the architectural HI/LO pair.
//  HI/LO feed the ALU operand path for MFHI/MFLO.

---
 rtl/mult_div_unit.sv | 195 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO, WIDTH+2 cycle latency.
// Ports: start/op/a/b launch, flush aborts, hi_we/lo_we/wdata = MTHI/MTLO,
// busy stalls the pipe, done pulses with new hi/lo. MDU_DIVZERO_FLAG_EN adds div_by_zero.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MDU_DIVZERO_FLAG_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_DIV, S_FIX
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               divz_q, divz_d;
  logic               is_div_q, is_div_d;
  logic               done_q, done_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_new;
  logic               rem_ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic               last;

  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

  // acc = {partial product, remaining multiplier bits}
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, m_q} : '0);

  // acc = {partial remainder, dividend bits shifting into quotient}
  assign rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_ge  = rem_sh >= {1'b0, m_q};
  assign rem_new = WIDTH'(rem_sh - {1'b0, m_q});

  assign prod = neg_res_q ? -acc_q : acc_q;
  assign quo  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH]
                          : acc_q[2*WIDTH-1:WIDTH];
  assign last = cnt_q == CW'(WIDTH - 1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    m_d       = m_q;
    a_d       = a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    divz_d    = divz_q;
    is_div_d  = is_div_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !flush) begin
          state_d   = op[1] ? S_DIV : S_MUL;
          cnt_d     = '0;
          m_d       = op[1] ? mag_b : mag_a;
          acc_d     = {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
          a_d       = a;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          divz_d    = b == '0;
          is_div_d  = op[1];
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (last) state_d = S_FIX;
      end
      S_DIV: begin
        acc_d = {rem_ge ? rem_new : rem_sh[WIDTH-1:0],
                 acc_q[WIDTH-2:0], rem_ge};
        cnt_d = cnt_q + 1'b1;
        if (last) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          {hi_d, lo_d} = prod;
        end else if (divz_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A squash discards the op, including a result about to retire.
    if (flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      m_q       <= '0;
      a_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      is_div_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      a_q       <= a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      divz_q    <= divz_d;
      is_div_q  <= is_div_d;
      done_q    <= done_d;
    end
  end

  assign busy = state_q != S_IDLE;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

`ifdef MDU_DIVZERO_FLAG_EN
  logic dz_q, dz_d;

  always_comb begin
    dz_d = dz_q;
    if (state_q == S_IDLE &&
        ((start && !flush) || hi_we || lo_we))
      dz_d = 1'b0;
    if (state_q == S_FIX && !flush)
      dz_d = is_div_q & divz_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dz_q <= 1'b0;
    else        dz_q <= dz_d;
  end

  assign div_by_zero = dz_q;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit.
// Stimulus pushes model results; a negedge monitor pops on done.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [1:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] wdata = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;
`ifdef MDU_DIVZERO_FLAG_EN
  logic         dz;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           due;
    logic         dz;
  } exp_t;

  exp_t sb[$];

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .a(a), .b(b), .flush(flush), .hi_we(hi_we),
    .lo_we(lo_we), .wdata(wdata), .busy(busy),
    .done(done), .hi(hi), .lo(lo)
`ifdef MDU_DIVZERO_FLAG_EN
    , .div_by_zero(dz)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [W-1:0] act,
                     logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result {hi, lo} from plain integer arithmetic.
  function automatic logic [2*W-1:0] model(logic [1:0] o,
      logic [W-1:0] x, logic [W-1:0] y);
    longint sx, sy;
    longint unsigned ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      2'd0: return 64'(sx * sy);
      2'd1: return 64'(ux * uy);
      2'd2: begin
        if (y == '0) return {x, {W{1'b1}}};
        // -2^31 / -1 gives +2^31, which wraps to 0x8000_0000
        return {W'(sx % sy), W'(sx / sy)};
      end
      default: begin
        if (y == '0) return {x, {W{1'b1}}};
        return {W'(ux % uy), W'(ux / uy)};
      end
    endcase
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(5))
      0: return '0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Caller is positioned at a negedge; start is sampled at the next edge.
  task automatic issue(logic [1:0] o, logic [W-1:0] x,
                       logic [W-1:0] y);
    exp_t e;
    logic [2*W-1:0] r;
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    r = model(o, x, y);
    e.hi = r[2*W-1:W];
    e.lo = r[W-1:0];
    e.due = cyc + W + 2;
    e.dz = o[1] && (y == '0);
    @(posedge clk);
    sb.push_back(e);
    #1;
    start = 1'b0;
    op = 2'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_idle: got busy expected idle");
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    logic eb;
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got 1 expected 0");
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.due));
          chk("hi", hi, e.hi);
          chk("lo", lo, e.lo);
`ifdef MDU_DIVZERO_FLAG_EN
          chk("div_by_zero", {31'b0, dz}, {31'b0, e.dz});
`endif
        end
      end else if (sb.size() > 0 && cyc >= sb[0].due) begin
        checks++;
        failures++;
        $display("FAIL late_done: got cycle %0d expected %0d",
                 cyc, sb[0].due);
        void'(sb.pop_front());
      end
      eb = sb.size() > 0 && cyc < sb[0].due;
      chk("busy", {31'b0, busy}, {31'b0, eb});
`ifdef MDU_DIVZERO_FLAG_EN
      if (eb) chk("dz_clear", {31'b0, dz}, '0);
`endif
    end
  end

  initial begin
    int c;
    logic [W-1:0] h0, l0;
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    logic [W-1:0] h0, l0;
    repeat (3) @(negedge clk);
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    chk("rst_busy", {31'b0, busy}, '0);
    chk("rst_done", {31'b0, done}, '0);
`ifdef MDU_DIVZERO_FLAG_EN
    chk("rst_dz", {31'b0, dz}, '0);
`endif
    rst_n = 1'b1;

    @(negedge clk); issue(2'd0, -32'sd3, 32'd5); wait_idle();
    @(negedge clk); issue(2'd1, '1, '1); wait_idle();
    @(negedge clk); issue(2'd2, -32'sd7, 32'd2); wait_idle();
    @(negedge clk); issue(2'd3, 32'd21, 32'd3); wait_idle();
    @(negedge clk); issue(2'd3, 32'd7, '0); wait_idle();
`ifdef MDU_DIVZERO_FLAG_EN
    repeat (3) @(negedge clk);
    chk("dz_hold", {31'b0, dz}, 32'd1);
`endif
    @(negedge clk); issue(2'd2, 32'h8000_0000, '1); wait_idle();
    @(negedge clk); issue(2'd2, -32'sd8, '0); wait_idle();
`ifdef MDU_DIVZERO_FLAG_EN
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h55;
    @(negedge clk);
    hi_we = 1'b0;
    chk("dz_wr_clear", {31'b0, dz}, '0);
`endif

    // flush mid-op, then a fresh op
    h0 = hi; l0 = lo;
    @(negedge clk);
    c = cyc;
    issue(2'd0, 32'd9, 32'd10);
    while (cyc < c + 10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    sb.delete();
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_hi", hi, h0);
    chk("flush_lo", lo, l0);
    while (cyc < c + 12) @(negedge clk);
    issue(2'd0, 32'd9, 32'd10);
    wait_idle();

    // start dropped by flush in IDLE
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'd1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_drop", {31'b0, busy}, '0);

    // start while busy ignored; MTLO while busy ignored
    @(negedge clk);
    issue(2'd1, 32'h1234_5678, 32'h9abc_def0);
    repeat (4) @(negedge clk);
    l0 = lo;
    start = 1'b1; op = 2'd2; a = 32'd99; b = 32'd4;
    lo_we = 1'b1; wdata = 32'hCAFE;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    chk("busy_mtlo", lo, l0);
    wait_idle();

    // MTHI / MTLO in IDLE
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", hi, 32'h1234);
    lo_we = 1'b1; wdata = 32'h5678;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo", lo, 32'h5678);

    // MTHI together with start: write lands first
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hDEAD;
    issue(2'd3, 32'd100, 32'd9);
    hi_we = 1'b0;
    @(negedge clk);
    chk("mthi_start", hi, 32'hDEAD);
    // start in the done cycle
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    issue(2'd0, -32'sd100, -32'sd7);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      issue(2'($urandom), pick(), pick());
      wait_idle();
    end

    // async reset mid-DIV
    @(negedge clk);
    c = cyc;
    issue(2'd2, 32'd100, 32'd7);
    while (cyc < c + 15) @(negedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("arst_hi", hi, '0);
    chk("arst_lo", lo, '0);
    chk("arst_busy", {31'b0, busy}, '0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    issue(2'd1, 32'd6, 32'd7);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
